reg_file_64: RTL and testbench
==============================

// Module: reg_file_64
// PURPOSE
//  LEGv8 register file: 32 x 64-bit GPRs, two read ports, one write port.
//  Read port 2 index comes from the 5-bit Reg2Loc select mux. Read data feeds
//  the ALU, and the 64-bit ALUSrc mux selects between read_data2 and the immediate.
//  Reads are registered (1-cycle latency). X31 is XZR.
// PARAMETERS
//  DATA_W   64   register width in bits
//  ADDR_W   5    register index width; NREGS = 2**ADDR_W = 32
//  ZR_IDX   31   index hard-wired to zero (XZR)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous reset, active-low
//  rd_en        in   1       capture a new read this cycle
//  read_reg1    in   ADDR_W  read port 1 index (Rn)
//  read_reg2    in   ADDR_W  read port 2 index (Reg2Loc mux output)
//  reg_write    in   1       write enable
//  write_reg    in   ADDR_W  write index (Rd)
//  write_data   in   DATA_W  write data (MemtoReg mux output)
//  read_data1   out  DATA_W  registered port 1 data
//  read_data2   out  DATA_W  registered port 2 data
//  rd_valid     out  1       read_data1/2 hold data captured on the previous rd_en
// BEHAVIOUR
//  - Reset (rst_n=0, async): all 32 registers = 0; read_data1 = 0;
//    read_data2 = 0; rd_valid = 0. Outputs are held while rst_n is low. The first
//    rising edge after release behaves normally.
//  - Write: at a posedge with reg_write=1 and write_reg!=ZR_IDX, regs[write_reg]
//    <= write_data. Writes to ZR_IDX are silently discarded; regs[31] stays 0.
//  - Read: at a posedge with rd_en=1, read_dataN <= (read_regN==ZR_IDX) ? 0 :
//    regs[read_regN]; rd_valid <= 1. Data appears the cycle after rd_en.
//  - rd_en=0: read_data1/2 hold their last values; rd_valid <= 0.
//  - Both ports may address the same register; both return identical data.
//  - Same-edge read and write to the same index: see CONFIGURATION. A read of
//    ZR_IDX always returns 0, regardless of any write.
//  - Read and write at different indices in the same edge are independent.
//  - Reset asserted mid-operation: an in-flight write is lost; the register
//    array and outputs clear immediately. No partial state remains.
//  - Widths: all data paths are exactly DATA_W. No sign or zero extension inside.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a write and a read to the same non-XZR index on
//    the same edge return write_data (write-first). This removes the
//    WB->decode hazard.
//  REGFILE_BYPASS_EN undefined: the same case returns the pre-write (old) value
//    (read-first). The new value is visible on the next rd_en.
// TESTING
//  1 reset: preload X1=0xAAAA, then pulse rst_n low mid-cycle -> all outputs
//    0 at once; read X1 after release -> 0.
//  2 write/read: write X5=0x0123_4567_89AB_CDEF; next cycle rd_en with
//    read_reg1=5 -> read_data1=0x0123_4567_89AB_CDEF and rd_valid=1 one cycle later.
//  3 XZR: write X31=0xFFFF_FFFF_FFFF_FFFF, then read both ports at 31 -> 0, 0.
//  4 collision: X7=0x10; same edge write X7=0x20 and read X7 -> 0x20 with
//    BYPASS_EN, 0x10 without; a follow-up read -> 0x20 in both builds.
//  5 hold: rd_en=1 for X2=0x3 then rd_en=0 for 3 cycles while writing X2=0x9
//    -> read_data1 stays 0x3; rd_valid=0 from the second cycle on.
//  6 dual port: X3=0x33, X4=0x44; read_reg1=3, read_reg2=4 -> 0x33/0x44; then
//    both at 4 -> 0x44/0x44.

Source files
------------

// File: rtl/reg_file_64.sv
// LEGv8 register file: 32 x 64-bit GPRs, two registered read ports, one write port, X31 = XZR.
// Same-edge read/write of one index returns the new value when REGFILE_BYPASS_EN is defined, else the old one.
module reg_file_64 #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int ZR_IDX = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              rd_valid
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZR_IDX);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] read_data1_q, read_data1_d;
  logic [DATA_W-1:0] read_data2_q, read_data2_d;
  logic              rd_valid_q;
  logic              wr_live;

  // XZR is never written, so its storage stays at the reset value.
  assign wr_live = reg_write && (write_reg != ZR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data1_d = (read_reg1 == ZR) ? '0 : regs_q[read_reg1];
    read_data2_d = (read_reg2 == ZR) ? '0 : regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    // wr_live already excludes XZR, so a bypassed read never returns nonzero for X31.
    if (wr_live && (write_reg == read_reg1)) begin
      read_data1_d = write_data;
    end
    if (wr_live && (write_reg == read_reg2)) begin
      read_data2_d = write_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data1_q <= '0;
      read_data2_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      if (rd_en) begin
        read_data1_q <= read_data1_d;
        read_data2_q <= read_data2_d;
      end
      rd_valid_q <= rd_en;
    end
  end

  assign read_data1 = read_data1_q;
  assign read_data2 = read_data2_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_reg_file_64.sv
// Self-checking bench for reg_file_64: directed scenarios then random traffic against an array model.
module tb_reg_file_64;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic        rd_valid;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [32];
  logic [63:0] exp1, exp2;
  logic        expv;

  reg_file_64 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .rd_valid   (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wr, input logic [63:0] wd);
    if (r == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wr == r) return wd;
`endif
    return model[r];
  endfunction

  task automatic check_outputs(input string tag);
    checks++;
    assert (read_data1 === exp1) else begin
      errors++;
      $error("FAIL %s read_data1 got %h expected %h", tag, read_data1, exp1);
    end
    checks++;
    assert (read_data2 === exp2) else begin
      errors++;
      $error("FAIL %s read_data2 got %h expected %h", tag, read_data2, exp2);
    end
    checks++;
    assert (rd_valid === expv) else begin
      errors++;
      $error("FAIL %s rd_valid got %b expected %b", tag, rd_valid, expv);
    end
    $display("%s re=%b r1=%0d r2=%0d we=%b wr=%0d wd=%h -> rd1=%h rd2=%h v=%b",
             tag, rd_en, read_reg1, read_reg2, reg_write, write_reg, write_data,
             read_data1, read_data2, rd_valid);
  endtask

  // Called one time unit after a rising edge; applies inputs across the next edge.
  task automatic step(input logic re, input logic [4:0] r1, input logic [4:0] r2,
                      input logic we, input logic [4:0] wr, input logic [63:0] wd,
                      input string tag);
    rd_en = re; read_reg1 = r1; read_reg2 = r2;
    reg_write = we; write_reg = wr; write_data = wd;
    @(posedge clk);
    #1;
    if (re) begin
      exp1 = ref_read(r1, we, wr, wd);
      exp2 = ref_read(r2, we, wr, wd);
    end
    expv = re;
    if (we && wr != 5'd31) model[wr] = wd;
    check_outputs(tag);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    exp1 = 64'd0; exp2 = 64'd0; expv = 1'b0;
  endtask

  initial begin
    logic [4:0]  r1, r2, wr;
    logic [63:0] wd;
    rst_n = 1'b1;
    rd_en = 1'b0; read_reg1 = '0; read_reg2 = '0;
    reg_write = 1'b0; write_reg = '0; write_data = '0;
    model_clear();
    #2 rst_n = 1'b0;
    #1 check_outputs("reset_assert");
    repeat (2) @(posedge clk);
    #1 check_outputs("reset_hold");
    rst_n = 1'b1;

    // Reset mid-operation, with a write in flight across the reset edge.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 64'hAAAA, "rst_preload");
    step(1'b1, 5'd1, 5'd1, 1'b0, 5'd0, 64'd0, "rst_read_pre");
    rd_en = 1'b1; reg_write = 1'b1; write_reg = 5'd1; write_data = 64'h5555;
    #3 rst_n = 1'b0;
    model_clear();
    #1 check_outputs("rst_async_clear");
    @(posedge clk);
    #1 check_outputs("rst_held");
    rst_n = 1'b1;
    step(1'b1, 5'd1, 5'd1, 1'b0, 5'd0, 64'd0, "rst_read_x1");

    // Write then read.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, "wr_x5");
    step(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 64'd0, "rd_x5");

    // XZR ignores writes.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, "wr_xzr");
    step(1'b1, 5'd31, 5'd31, 1'b0, 5'd0, 64'd0, "rd_xzr");
    step(1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, "rdwr_xzr");

    // Same-edge collision on X7.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 64'h10, "wr_x7");
    step(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 64'h20, "collide_x7");
    step(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 64'd0, "followup_x7");

    // Hold behaviour while rd_en is low.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 64'h3, "wr_x2");
    step(1'b1, 5'd2, 5'd2, 1'b0, 5'd0, 64'd0, "rd_x2");
    for (int i = 0; i < 3; i++) step(1'b0, 5'd2, 5'd2, 1'b1, 5'd2, 64'h9, "hold_x2");

    // Dual-port reads.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 64'h33, "wr_x3");
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 64'h44, "wr_x4");
    step(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 64'd0, "rd_x3_x4");
    step(1'b1, 5'd4, 5'd4, 1'b0, 5'd0, 64'd0, "rd_x4_x4");

    // Random traffic with deliberately frequent index collisions.
    for (int i = 0; i < 300; i++) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      wr = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), r1, r2, 1'($urandom_range(0, 1)), wr, wd, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
